// File: rtl/never8_pkg.sv
// never8_pkg: shared types and widths for the Never8 control slice.
//   PC_W     - program counter / immediate width
//   DATA_W   - datapath width
//   opcode_t - 3-bit instruction opcodes (IR[7:5])
//   state_t  - sequencer states
package never8_pkg;

   localparam int unsigned PC_W   = 5;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_LDI  = 3'b010,
      OP_JMP  = 3'b011,
      OP_JZ   = 3'b100,
      OP_JC   = 3'b101,
      OP_OUT  = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_HALTED,
      ST_WAIT_STEP
   } state_t;

endpackage

// File: rtl/never8_control_if.sv
// never8_control_if: instruction-memory fetch handshake.
//   imem_req  - fetch request (master -> slave)
//   imem_addr - fetch address (master -> slave)
//   imem_ack  - imem_data valid this cycle (slave -> master)
//   imem_data - instruction word (slave -> master)
interface never8_control_if;

   logic                            imem_req;
   logic [never8_pkg::PC_W-1:0]     imem_addr;
   logic                            imem_ack;
   logic [never8_pkg::DATA_W-1:0]   imem_data;

   modport master (output imem_req, imem_addr, input imem_ack, imem_data);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);

endinterface

// File: rtl/never8_pc.sv
// never8_pc: program counter with increment, load and reset value.
//   clk, rst_n - clock, asynchronous active-low reset (loads RESET_PC)
//   inc        - advance PC by one (wraps modulo 2**PC_W)
//   load       - load load_val; takes priority over inc
//   load_val   - jump target
//   pc         - current PC
module never8_pc
   import never8_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/never8_control.sv
// never8_control: fetch/decode/execute sequencer for the Never8 core.
//   clk, rst_n     - clock, asynchronous active-low reset
//   step           - single-step release (only with NEVER8_SINGLE_STEP_EN)
//   imem           - fetch handshake (master side of never8_control_if)
//   alu_opcode     - IR[7:5] to external ALU
//   alu_a          - IR[4:0] to external ALU
//   acc            - accumulator, to ALU b input
//   alu_data_out, alu_c, alu_zflag - ALU results, committed on ADD/SUB
//   out_data       - accumulator value latched by OUT
//   out_valid      - one-cycle OUT strobe
//   halted         - core stopped by HALT, cleared only by reset
// Optional feature macro: NEVER8_SINGLE_STEP_EN adds the step port and a
// WAIT_STEP state after EXECUTE.
module never8_control
   import never8_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 5'd0
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef NEVER8_SINGLE_STEP_EN
   input  logic              step,
`endif
   never8_control_if.master  imem,
   output logic [2:0]        alu_opcode,
   output logic [PC_W-1:0]   alu_a,
   output logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] alu_data_out,
   input  logic              alu_c,
   input  logic              alu_zflag,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted
);

   state_t              state;
   logic [DATA_W-1:0]   ir;
   logic                c_flag;
   logic                z_flag;
   logic                req_q;
   logic [PC_W-1:0]     pc;
   logic                pc_inc;
   logic                jump_taken;
   opcode_t             op;
   logic [PC_W-1:0]     imm;

   assign op         = opcode_t'(ir[7:5]);
   assign imm        = ir[PC_W-1:0];
   assign alu_opcode = ir[7:5];
   assign alu_a      = imm;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc;

   // PC advances on the accepted fetch; a taken jump reloads it in EXECUTE.
   assign pc_inc = (state == ST_FETCH) && req_q && imem.imem_ack;

   always_comb begin
      jump_taken = 1'b0;
      if (state == ST_EXECUTE) begin
         case (op)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = z_flag;
            OP_JC:   jump_taken = c_flag;
            default: jump_taken = 1'b0;
         endcase
      end
   end

   never8_pc #(.RESET_PC(RESET_PC)) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (pc_inc),
      .load     (jump_taken),
      .load_val (imm),
      .pc       (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FETCH;
         ir        <= '0;
         acc       <= '0;
         c_flag    <= 1'b0;
         z_flag    <= 1'b0;
         req_q     <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         halted    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            // req is raised on entry (by EXECUTE, or here after reset), so an
            // ack is only honoured once the request is actually visible.
            ST_FETCH: begin
               if (!req_q) begin
                  req_q <= 1'b1;
               end else if (imem.imem_ack) begin
                  ir    <= imem.imem_data;
                  req_q <= 1'b0;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (op == OP_HALT) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end else begin
                  state <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               case (op)
                  OP_ADD, OP_SUB: begin
                     acc    <= alu_data_out;
                     c_flag <= alu_c;
                     z_flag <= alu_zflag;
                  end
                  OP_LDI: begin
                     acc    <= {{(DATA_W-PC_W){1'b0}}, imm};
                     z_flag <= (imm == '0);
                  end
                  OP_OUT: begin
                     out_data  <= acc;
                     out_valid <= 1'b1;
                  end
                  default: ;
               endcase
`ifdef NEVER8_SINGLE_STEP_EN
               state <= ST_WAIT_STEP;
`else
               state <= ST_FETCH;
               req_q <= 1'b1;
`endif
            end
`ifdef NEVER8_SINGLE_STEP_EN
            ST_WAIT_STEP: begin
               if (step) begin
                  state <= ST_FETCH;
                  req_q <= 1'b1;
               end
            end
`endif
            ST_HALTED: ;
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_never8_control.sv
// tb_never8_control: directed bench for never8_control with a behavioural
// ALU, an instruction responder driven step by step, and scoreboard queues
// for fetch address, accumulator and OUT data.
module tb_never8_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] alu_opcode;
   logic [4:0] alu_a;
   logic [7:0] acc;
   logic [7:0] alu_data_out;
   logic       alu_c;
   logic       alu_zflag;
   logic [7:0] out_data;
   logic       out_valid;
   logic       halted;

   never8_control_if bus ();

   int passed = 0;
   int total  = 0;

   logic [4:0] addr_q[$];
   logic [7:0] acc_q[$];
   logic [7:0] out_q[$];

   always #5 clk = ~clk;

   never8_control #(.RESET_PC(5'd0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef NEVER8_SINGLE_STEP_EN
      .step         (1'b1),
`endif
      .imem         (bus),
      .alu_opcode   (alu_opcode),
      .alu_a        (alu_a),
      .acc          (acc),
      .alu_data_out (alu_data_out),
      .alu_c        (alu_c),
      .alu_zflag    (alu_zflag),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .halted       (halted)
   );

   // Behavioural ALU: ADD carry-out, SUB carry = no borrow.
   always_comb begin
      logic [8:0] s;
      s = {1'b0, acc};
      case (alu_opcode)
         3'b000: s = {1'b0, acc} + {4'b0, alu_a};
         3'b001: s = {1'b0, acc} - {4'b0, alu_a};
         default: s = {1'b0, acc};
      endcase
      alu_data_out = s[7:0];
      alu_c        = (alu_opcode == 3'b001) ? ~s[8] : s[8];
      alu_zflag    = (s[7:0] == 8'h00);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // OUT scoreboard: every strobe must match a queued OUT value.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (out_q.size() == 0) check("out_valid_extra", {31'b0, out_valid}, 32'd0);
         else check("out_data", {24'b0, out_data}, {24'b0, out_q.pop_front()});
      end
   end

   task automatic wait_fetch();
      int unsigned n = 0;
      while (!bus.imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_timeout", {31'b0, bus.imem_req}, 32'd1);
      check("fetch_addr", {27'b0, bus.imem_addr}, {27'b0, addr_q.pop_front()});
      check("acc", {24'b0, acc}, {24'b0, acc_q.pop_front()});
   endtask

   // Fetch one instruction, optionally delaying the ack, and queue the
   // expected PC/acc seen at the following fetch.
   task automatic issue(input logic [7:0] instr, input int unsigned dly,
                        input logic [4:0] nxt_pc, input logic [7:0] nxt_acc);
      logic [4:0] a0;
      wait_fetch();
      a0 = bus.imem_addr;
      repeat (dly) begin
         @(negedge clk);
         check("addr_stable", {27'b0, bus.imem_addr}, {27'b0, a0});
         check("req_held", {31'b0, bus.imem_req}, 32'd1);
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = instr;
      if (instr[7:5] == 3'b110) out_q.push_back(nxt_acc);
      @(negedge clk);
      // Stray ack with a HALT word while in DECODE must be ignored.
      bus.imem_data = 8'hE0;
      @(negedge clk);
      bus.imem_ack  = 1'b0;
      bus.imem_data = 8'h00;
      addr_q.push_back(nxt_pc);
      acc_q.push_back(nxt_acc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, bus.imem_req}, 32'd0);
      check("rst_addr", {27'b0, bus.imem_addr}, 32'd0);
      check("rst_acc", {24'b0, acc}, 32'd0);
      check("rst_out_data", {24'b0, out_data}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("req_first_clock", {31'b0, bus.imem_req}, 32'd1);
      @(negedge clk);

      addr_q.push_back(5'd0);
      acc_q.push_back(8'h00);
      issue(8'h43, 0, 5'd1,  8'h03);   // LDI 3
      issue(8'h25, 0, 5'd2,  8'hFE);   // SUB 5 -> C=0 Z=0
      issue(8'hAA, 0, 5'd3,  8'hFE);   // JC 10 not taken
      issue(8'h8A, 0, 5'd4,  8'hFE);   // JZ 10 not taken
      issue(8'h45, 0, 5'd5,  8'h05);   // LDI 5
      issue(8'h25, 0, 5'd6,  8'h00);   // SUB 5 -> C=1 Z=1
      issue(8'h89, 0, 5'd9,  8'h00);   // JZ 9 taken
      issue(8'hAC, 0, 5'd12, 8'h00);   // JC 12 taken
      issue(8'h5F, 0, 5'd13, 8'h1F);   // LDI 31
      for (int i = 1; i <= 7; i++)
         issue(8'h1F, 0, 5'(13 + i), 8'(31 * (i + 1)));   // ADD 31, ends at F8
      issue(8'hA0, 0, 5'd21, 8'hF8);   // JC 0 not taken (C=0)
      issue(8'h1F, 0, 5'd22, 8'h17);   // ADD 31 -> 0x117, C=1
      issue(8'hB8, 0, 5'd24, 8'h17);   // JC 24 taken
      issue(8'h55, 0, 5'd25, 8'h15);   // LDI 21
      issue(8'h15, 0, 5'd26, 8'h2A);   // ADD 21
      issue(8'hC0, 0, 5'd27, 8'h2A);   // OUT
      issue(8'h7F, 0, 5'd31, 8'h2A);   // JMP 31
      issue(8'h47, 3, 5'd0,  8'h07);   // LDI 7 at 31, delayed ack, wraps
      issue(8'hE0, 0, 5'd0,  8'h07);   // HALT

      check("halted", {31'b0, halted}, 32'd1);
      check("acc_halt", {24'b0, acc}, {24'b0, acc_q.pop_front()});
      check("out_data_hold", {24'b0, out_data}, 32'h2A);
      repeat (8) begin
         @(negedge clk);
         check("halt_no_req", {31'b0, bus.imem_req}, 32'd0);
      end
      check("out_pending", out_q.size(), 32'd0);

      rst_n = 1'b0;
      #1 check("halt_cleared", {31'b0, halted}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      addr_q.delete();
      acc_q.delete();
      addr_q.push_back(5'd0);
      acc_q.push_back(8'h00);
      issue(8'h49, 0, 5'd1, 8'h09);    // LDI 9
      wait_fetch();                    // sitting in FETCH at address 1
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midfetch_req", {31'b0, bus.imem_req}, 32'd0);
      check("midfetch_pc", {27'b0, bus.imem_addr}, 32'd0);
      check("midfetch_acc", {24'b0, acc}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      addr_q.push_back(5'd0);
      acc_q.push_back(8'h00);
      issue(8'h41, 0, 5'd1, 8'h01);    // LDI 1 after reset
      wait_fetch();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
